// File: rtl/canny_seq_pkg.sv
// Shared types and constants for the canny frame sequencer.
package canny_seq_pkg;

  localparam int DIM_W          = 16;
  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL    = 3'd1,
    STREAM  = 3'd2,
    DISCARD = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/canny_frame_sequencer_if.sv
// Control-packet side of the sequencer: decoded packet in, encoder control out.
interface canny_frame_sequencer_if #(
  parameter int DIM_W = canny_seq_pkg::DIM_W
);
  // vip_ctrl_valid presents one packet per high cycle (no back-pressure);
  // vip_ctrl_send is a one-cycle strobe issued only while vip_ctrl_busy is low.
  logic             vip_ctrl_valid;
  logic [DIM_W-1:0] width_in;
  logic [DIM_W-1:0] height_in;
  logic [3:0]       interlaced_in;
  logic             vip_ctrl_busy;
  logic             vip_ctrl_send;
  logic [DIM_W-1:0] width_out;
  logic [DIM_W-1:0] height_out;
  logic [3:0]       interlaced_out;

  modport master (
    output vip_ctrl_valid, width_in, height_in, interlaced_in, vip_ctrl_busy,
    input  vip_ctrl_send, width_out, height_out, interlaced_out
  );

  modport slave (
    input  vip_ctrl_valid, width_in, height_in, interlaced_in, vip_ctrl_busy,
    output vip_ctrl_send, width_out, height_out, interlaced_out
  );
endinterface

// File: rtl/canny_seq_out_stage.sv
// Output beat register: follows the FIFO read strobe one cycle later and holds under stall.
module canny_seq_out_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  input  logic eov_mark,
  input  logic out_stall,
  output logic out_write,
  output logic out_eov,
  output logic eov_beat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_write <= 1'b0;
      out_eov   <= 1'b0;
    end else if (!(out_write && out_stall)) begin
      out_write <= rd_en;
      out_eov   <= rd_en & eov_mark;
    end
  end

  assign eov_beat = out_write & out_eov & ~out_stall;

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame sequencer around the canny pipeline FIFOs: packet handling, pixel admission,
// output framing. Statistics counters exist only when CANNY_SEQ_STATS_EN is defined.
module canny_frame_sequencer #(
  parameter int DIM_W          = canny_seq_pkg::DIM_W,
  parameter int DEFAULT_WIDTH  = canny_seq_pkg::DEFAULT_WIDTH,
  parameter int DEFAULT_HEIGHT = canny_seq_pkg::DEFAULT_HEIGHT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  canny_frame_sequencer_if.slave     ctrl,
  input  logic                       in_valid,
  input  logic                       in_eov,
  output logic                       in_read,
  input  logic                       pipe_full,
  output logic                       pipe_wr_en,
  input  logic                       pipe_empty,
  output logic                       pipe_rd_en,
  input  logic                       out_stall,
  output logic                       out_write,
  output logic                       out_eov,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_long,
  output logic [15:0]                frame_count,
  output logic [7:0]                 err_count,
  output canny_seq_pkg::seq_state_t  dbg_state
);
  import canny_seq_pkg::*;

  localparam int CW = 2 * DIM_W;

  seq_state_t       state, state_next;
  logic [DIM_W-1:0] width_q, height_q, pend_w, pend_h, pkt_w, pkt_h;
  logic [3:0]       il_q, pend_il, pkt_il;
  logic             pend_valid, pkt_avail, pkt_ok;
  logic [CW-1:0]    total, in_cnt, out_cnt, target, in_cnt_inc, tgt_val;
  logic             target_known, eov_seen;
  logic             take_pkt, drop_pkt, tgt_load, out_active, eov_mark, eov_beat;

  // A packet arriving in IDLE is newer than anything pending, so it wins.
  assign pkt_avail  = ctrl.vip_ctrl_valid | pend_valid;
  assign pkt_w      = ctrl.vip_ctrl_valid ? ctrl.width_in      : pend_w;
  assign pkt_h      = ctrl.vip_ctrl_valid ? ctrl.height_in     : pend_h;
  assign pkt_il     = ctrl.vip_ctrl_valid ? ctrl.interlaced_in : pend_il;
  assign pkt_ok     = (pkt_w != '0) && (pkt_h != '0);
  assign in_cnt_inc = in_cnt + CW'(1);

  always_comb begin
    state_next         = state;
    take_pkt           = 1'b0;
    drop_pkt           = 1'b0;
    ctrl.vip_ctrl_send = 1'b0;
    in_read            = 1'b0;
    pipe_wr_en         = 1'b0;
    tgt_load           = 1'b0;
    tgt_val            = in_cnt_inc;
    err_short          = 1'b0;
    err_long           = 1'b0;
    frame_done         = 1'b0;
    out_active         = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_avail) begin
          if (pkt_ok) begin
            take_pkt   = 1'b1;
            state_next = CTRL;
          end else begin
            drop_pkt  = 1'b1;
            err_short = 1'b1;
          end
        end
      end
      CTRL: begin
        if (!ctrl.vip_ctrl_busy) begin
          ctrl.vip_ctrl_send = 1'b1;
          state_next         = STREAM;
        end
      end
      STREAM: begin
        out_active = 1'b1;
        in_read    = ~pipe_full & ~out_stall & (in_cnt < total);
        pipe_wr_en = in_read & in_valid;
        if (pipe_wr_en) begin
          if (in_eov) begin
            tgt_load   = 1'b1;
            err_short  = (in_cnt_inc < total);
            state_next = DRAIN;
          end else if (in_cnt_inc == total) begin
            tgt_load   = 1'b1;
            tgt_val    = total;
            err_long   = 1'b1;
            state_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        out_active = 1'b1;
        in_read    = 1'b1;
        if (in_valid && in_eov) state_next = DRAIN;
      end
      DRAIN: begin
        out_active = 1'b1;
        // The last beat may already have left while surplus input was discarded.
        if (eov_beat || eov_seen) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pipe_rd_en = out_active & ~pipe_empty & (out_cnt < in_cnt) & ~(out_write & out_stall);
  assign eov_mark   = target_known & (out_cnt == target - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q      <= DIM_W'(DEFAULT_WIDTH);
      height_q     <= DIM_W'(DEFAULT_HEIGHT);
      il_q         <= '0;
      pend_valid   <= 1'b0;
      pend_w       <= '0;
      pend_h       <= '0;
      pend_il      <= '0;
      total        <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      target       <= '0;
      target_known <= 1'b0;
      eov_seen     <= 1'b0;
    end else begin
      if (state != IDLE && ctrl.vip_ctrl_valid) begin
        pend_valid <= 1'b1;
        pend_w     <= ctrl.width_in;
        pend_h     <= ctrl.height_in;
        pend_il    <= ctrl.interlaced_in;
      end else if (take_pkt || drop_pkt) begin
        pend_valid <= 1'b0;
      end
      if (take_pkt) begin
        width_q      <= pkt_w;
        height_q     <= pkt_h;
        il_q         <= pkt_il;
        total        <= CW'(pkt_w) * CW'(pkt_h);
        in_cnt       <= '0;
        out_cnt      <= '0;
        target       <= '0;
        target_known <= 1'b0;
        eov_seen     <= 1'b0;
      end else begin
        if (pipe_wr_en) in_cnt  <= in_cnt_inc;
        if (pipe_rd_en) out_cnt <= out_cnt + CW'(1);
        if (tgt_load) begin
          target       <= tgt_val;
          target_known <= 1'b1;
        end
        if (eov_beat) eov_seen <= 1'b1;
      end
    end
  end

  canny_seq_out_stage u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (pipe_rd_en),
    .eov_mark  (eov_mark),
    .out_stall (out_stall),
    .out_write (out_write),
    .out_eov   (out_eov),
    .eov_beat  (eov_beat)
  );

  assign ctrl.width_out      = width_q;
  assign ctrl.height_out     = height_q;
  assign ctrl.interlaced_out = il_q;
  assign busy                = (state != IDLE);
  assign dbg_state           = state;

`ifdef CANNY_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((err_short || err_long) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Bench for canny_frame_sequencer: directed frames plus random frames against a frame-level model.
module tb_canny_frame_sequencer;
  import canny_seq_pkg::*;

  localparam int PIPE_DEPTH = 4;

  logic clk, rst_n;
  logic in_valid, in_eov, in_read;
  logic pipe_full, pipe_wr_en, pipe_empty, pipe_rd_en;
  logic out_stall, out_write, out_eov;
  logic busy, frame_done, err_short, err_long;
  logic [15:0] frame_count;
  logic [7:0]  err_count;
  seq_state_t  dbg_state;
  logic [7:0]  in_id;

  canny_frame_sequencer_if #(.DIM_W(16)) ctrl_if ();

  canny_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl_if),
    .in_valid(in_valid), .in_eov(in_eov), .in_read(in_read),
    .pipe_full(pipe_full), .pipe_wr_en(pipe_wr_en),
    .pipe_empty(pipe_empty), .pipe_rd_en(pipe_rd_en),
    .out_stall(out_stall), .out_write(out_write), .out_eov(out_eov),
    .busy(busy), .frame_done(frame_done), .err_short(err_short), .err_long(err_long),
    .frame_count(frame_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  int wr_cnt = 0;
  int stall_force = 0;
  bit rand_en = 0;
  bit hold_empty = 0;

  logic [8:0]  exp_q[$];       // {eov, pixel id} per output beat
  logic [35:0] exp_send_q[$];  // {interlaced, height, width}
  logic [1:0]  exp_evt_q[$];   // 1 err_short, 2 err_long, 3 frame_done
  logic [7:0]  pipe_q[$];
  logic [7:0]  data_q = '0;
  bit          prev_hold = 0;
  logic        prev_eov = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic bail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected completion", name);
    report();
    $finish;
  endtask

  // reference model: frame-level outcome of w x h with n pixels, eov on the last one
  task automatic expect_frame(input int w, input int h, input int il, input int n);
    int total = w * h;
    int k = (n < total) ? n : total;
    if (total == 0) begin
      exp_evt_q.push_back(2'd1);
      if (exp_errs < 255) exp_errs++;
      return;
    end
    exp_send_q.push_back({4'(il), 16'(h), 16'(w)});
    for (int i = 0; i < k; i++) exp_q.push_back({(i == k - 1), 8'(i)});
    if (n < total) begin
      exp_evt_q.push_back(2'd1);
      if (exp_errs < 255) exp_errs++;
    end else if (n > total) begin
      exp_evt_q.push_back(2'd2);
      if (exp_errs < 255) exp_errs++;
    end
    exp_evt_q.push_back(2'd3);
    exp_frames++;
  endtask

  // driver tasks
  task automatic pulse_ctrl(input int w, input int h, input int il);
    @(posedge clk); #1;
    ctrl_if.vip_ctrl_valid = 1'b1;
    ctrl_if.width_in       = 16'(w);
    ctrl_if.height_in      = 16'(h);
    ctrl_if.interlaced_in  = 4'(il);
    @(posedge clk); #1;
    ctrl_if.vip_ctrl_valid = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int cnt, input bit eov_last);
    for (int i = 0; i < cnt; i++) begin
      int budget = 0;
      if (rand_en && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_eov   = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_id    = 8'(first + i);
      in_eov   = eov_last && (i == cnt - 1);
      forever begin
        @(negedge clk);
        if (in_read) break;
        budget++;
        if (budget > 2000) bail("pixel_accept_timeout");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_eov   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || exp_evt_q.size() != 0 || exp_send_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 4000) bail("frame_timeout");
    end
    repeat (2) @(negedge clk);
    check("pipe_residue", pipe_q.size(), 0);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int il, input int n);
    int total = w * h;
    wr_cnt = 0;
    expect_frame(w, h, il, n);
    pulse_ctrl(w, h, il);
    if (total > 0) send_pixels(0, n, 1'b1);
    wait_idle();
    check("pipe_wr_count", wr_cnt, (n < total) ? n : total);
  endtask

  task automatic check_stats(input string tag);
`ifdef CANNY_SEQ_STATS_EN
    check({tag, "_frame_count"}, frame_count, 16'(exp_frames));
    check({tag, "_err_count"}, err_count, 8'(exp_errs));
`else
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_count"}, err_count, 0);
`endif
  endtask

  // flow control and pipeline occupancy
  always @(posedge clk) begin
    #1;
    if (stall_force > 0) begin
      out_stall   = 1'b1;
      stall_force = stall_force - 1;
    end else begin
      out_stall = rand_en && ($urandom_range(0, 3) == 0);
    end
    pipe_full  = (pipe_q.size() >= PIPE_DEPTH) || (rand_en && $urandom_range(0, 7) == 0);
    pipe_empty = hold_empty || (pipe_q.size() == 0) || (rand_en && $urandom_range(0, 7) == 0);
    ctrl_if.vip_ctrl_busy = rand_en && ($urandom_range(0, 2) == 0);
  end

  // scoreboard monitor, also modelling the pipeline FIFO with one-cycle read latency
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
      data_q    = '0;
    end else begin
      if (prev_hold) begin
        check("hold_out_write", out_write, 1);
        check("hold_out_eov", out_eov, prev_eov);
      end
      prev_hold = out_write && out_stall;
      prev_eov  = out_eov;
      if (out_write && !out_stall) begin
        if (exp_q.size() == 0) note_fail("out_unexpected");
        else check("out_beat", {out_eov, data_q}, exp_q.pop_front());
      end
      if (pipe_rd_en) begin
        check("rd_while_empty", pipe_empty, 0);
        if (pipe_q.size() == 0) note_fail("pipe_underflow");
        else data_q = pipe_q.pop_front();
      end
      if (pipe_wr_en) begin
        check("wr_while_full", pipe_full, 0);
        pipe_q.push_back(in_id);
        wr_cnt++;
      end
      if (ctrl_if.vip_ctrl_send) begin
        if (exp_send_q.size() == 0) note_fail("send_unexpected");
        else check("ctrl_send", {ctrl_if.interlaced_out, ctrl_if.height_out, ctrl_if.width_out},
                   exp_send_q.pop_front());
      end
      if (err_short) begin
        if (exp_evt_q.size() == 0) note_fail("err_short_unexpected");
        else check("evt_err_short", 2'd1, exp_evt_q.pop_front());
      end
      if (err_long) begin
        if (exp_evt_q.size() == 0) note_fail("err_long_unexpected");
        else check("evt_err_long", 2'd2, exp_evt_q.pop_front());
      end
      if (frame_done) begin
        if (exp_evt_q.size() == 0) note_fail("frame_done_unexpected");
        else check("evt_frame_done", 2'd3, exp_evt_q.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_width_out"}, ctrl_if.width_out, 640);
    check({tag, "_height_out"}, ctrl_if.height_out, 480);
    check({tag, "_interlaced_out"}, ctrl_if.interlaced_out, 0);
    check({tag, "_out_write"}, out_write, 0);
    check({tag, "_pipe_rd_en"}, pipe_rd_en, 0);
    check({tag, "_in_read"}, in_read, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_eov = 1'b0; in_id = '0;
    out_stall = 1'b0; pipe_full = 1'b0; pipe_empty = 1'b1;
    ctrl_if.vip_ctrl_valid = 1'b0; ctrl_if.vip_ctrl_busy = 1'b0;
    ctrl_if.width_in = '0; ctrl_if.height_in = '0; ctrl_if.interlaced_in = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // nominal 4x2 frame
    run_frame(4, 2, 5, 8);
    // short frame: eov on the 5th pixel
    run_frame(4, 2, 0, 5);
    // long frame: 11 pixels, last three discarded
    run_frame(4, 2, 1, 11);

    // 3-cycle output stall mid-frame
    wr_cnt = 0;
    expect_frame(4, 2, 0, 8);
    pulse_ctrl(4, 2, 0);
    send_pixels(0, 3, 1'b0);
    stall_force = 3;
    send_pixels(3, 5, 1'b1);
    wait_idle();
    check("stall_wr_count", wr_cnt, 8);
    check_stats("pre_reset");

    // reset in the middle of a frame
    hold_empty = 1;
    expect_frame(4, 2, 0, 8);
    pulse_ctrl(4, 2, 0);
    send_pixels(0, 3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("abort_send_seen", exp_send_q.size(), 0);
    exp_q.delete(); exp_evt_q.delete(); exp_send_q.delete(); pipe_q.delete();
    exp_frames = 0; exp_errs = 0;
    hold_empty = 0;
    repeat (2) @(negedge clk);
    check_reset_values("midframe_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(4, 2, 3, 8);

    // packet arriving during STREAM is applied after the current frame
    wr_cnt = 0;
    expect_frame(4, 2, 2, 8);
    expect_frame(8, 1, 9, 8);
    pulse_ctrl(4, 2, 2);
    send_pixels(0, 2, 1'b0);
    pulse_ctrl(8, 1, 9);
    send_pixels(2, 6, 1'b1);
    send_pixels(0, 8, 1'b1);
    wait_idle();
    check("pending_wr_count", wr_cnt, 16);
    check("pending_width_out", ctrl_if.width_out, 8);
    check("pending_height_out", ctrl_if.height_out, 1);

    // zero-dimension packet is rejected
    run_frame(0, 3, 0, 0);

    // randomized frames with random back-pressure
    rand_en = 1;
    for (int f = 0; f < 30; f++) begin
      int w = $urandom_range(1, 6);
      int h = $urandom_range(1, 4);
      int il = $urandom_range(0, 15);
      int sel = $urandom_range(0, 9);
      int total = w * h;
      if (sel == 0) run_frame((h > 2) ? 0 : w, (h > 2) ? h : 0, il, 0);
      else if (sel <= 3) run_frame(w, h, il, $urandom_range(1, total));
      else if (sel <= 6) run_frame(w, h, il, total);
      else run_frame(w, h, il, total + $urandom_range(1, 3));
    end
    rand_en = 0;
    repeat (3) @(negedge clk);

    check_stats("final");
    check("final_out_queue", exp_q.size(), 0);
    check("final_evt_queue", exp_evt_q.size(), 0);
    check("final_send_queue", exp_send_q.size(), 0);
    report();
    $finish;
  end

  initial begin
    #2000000;
    bail("global_timeout");
  end

endmodule
